// File: rtl/rs_pkg.sv
// rs_pkg: shared constants, default widths and the reservation-station entry layout.
package rs_pkg;
    localparam int RS_DEPTH = 16;
    localparam int RS_CDB_N = 2;
    localparam int RS_TAG_W = 5;
    localparam int RS_DAT_W = 32;
    localparam int RS_OP_W  = 6;
    localparam int TAG_NONE = 0;

    typedef struct packed {
        logic                busy;
        logic [RS_OP_W-1:0]  op;
        logic [RS_DAT_W-1:0] pc;
        logic [RS_DAT_W-1:0] imm;
        logic [RS_TAG_W-1:0] qs1;
        logic [RS_TAG_W-1:0] qs2;
        logic [RS_DAT_W-1:0] vs1;
        logic [RS_DAT_W-1:0] vs2;
        logic [RS_TAG_W-1:0] qd;
    } rs_entry_t;
endpackage

// File: rtl/rs_prio_enc.sv
// rs_prio_enc: lowest-set-bit encoder with an any-hit flag.
module rs_prio_enc #(
    parameter int N = 16
) (
    input  logic [N-1:0]         req,
    output logic                 hit,
    output logic [$clog2(N)-1:0] idx
);
    always_comb begin
        idx = '0;
        for (int i = N - 1; i >= 0; i--)
            if (req[i]) idx = $clog2(N)'(i);
    end
    assign hit = |req;
endmodule

// File: rtl/rs_multi_cdb.sv
// rs_multi_cdb: reservation station with multi-channel CDB wakeup, allocation bypass,
// lowest-index issue selection over a valid/ready handshake, and single-cycle flush.
module rs_multi_cdb import rs_pkg::*; #(
    parameter int DEPTH = RS_DEPTH,
    parameter int CDB_N = RS_CDB_N,
    parameter int TAG_W = RS_TAG_W,
    parameter int DAT_W = RS_DAT_W,
    parameter int OP_W  = RS_OP_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [OP_W-1:0]        in_op,
    input  logic [DAT_W-1:0]       in_pc,
    input  logic [DAT_W-1:0]       in_imm,
    input  logic [TAG_W-1:0]       in_qs1,
    input  logic [TAG_W-1:0]       in_qs2,
    input  logic [DAT_W-1:0]       in_vs1,
    input  logic [DAT_W-1:0]       in_vs2,
    input  logic [TAG_W-1:0]       in_qd,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [OP_W-1:0]        out_op,
    output logic [DAT_W-1:0]       out_pc,
    output logic [DAT_W-1:0]       out_imm,
    output logic [DAT_W-1:0]       out_vs1,
    output logic [DAT_W-1:0]       out_vs2,
    output logic [TAG_W-1:0]       out_qd,
    input  logic [CDB_N-1:0]       cdb_valid,
    input  logic [CDB_N*TAG_W-1:0] cdb_tag,
    input  logic [CDB_N*DAT_W-1:0] cdb_data,
    output logic [$clog2(DEPTH):0] count
);
    localparam int IW = $clog2(DEPTH);
    localparam int CW = IW + 1;

    // Same layout as rs_entry_t, sized by this instance's parameters.
    typedef struct packed {
        logic             busy;
        logic [OP_W-1:0]  op;
        logic [DAT_W-1:0] pc;
        logic [DAT_W-1:0] imm;
        logic [TAG_W-1:0] qs1;
        logic [TAG_W-1:0] qs2;
        logic [DAT_W-1:0] vs1;
        logic [DAT_W-1:0] vs2;
        logic [TAG_W-1:0] qd;
    } ent_t;

    ent_t             entry_q [DEPTH];
    ent_t             entry_d [DEPTH];
    ent_t             nv;
    logic [CW-1:0]    count_q, count_d;
    logic [TAG_W-1:0] ctag [CDB_N];
    logic [DAT_W-1:0] cdat [CDB_N];
    logic [CDB_N-1:0] cv, b1, b2;
    logic [CDB_N-1:0] m [DEPTH][2];
    logic [DEPTH-1:0] free_v, rdy_v;
    logic [IW-1:0]    free_idx, rdy_idx;
    logic             free_hit, rdy_hit, alloc, issue;

    for (genvar c = 0; c < CDB_N; c++) begin : g_ch
        assign ctag[c] = cdb_tag[c*TAG_W +: TAG_W];
        assign cdat[c] = cdb_data[c*DAT_W +: DAT_W];
        assign cv[c]   = cdb_valid[c] && ctag[c] != TAG_W'(TAG_NONE);
        assign b1[c]   = cv[c] && ctag[c] == in_qs1;
        assign b2[c]   = cv[c] && ctag[c] == in_qs2;
    end

    for (genvar e = 0; e < DEPTH; e++) begin : g_ent
        assign free_v[e] = !entry_q[e].busy;
        assign rdy_v[e]  = entry_q[e].busy && entry_q[e].qs1 == TAG_W'(TAG_NONE)
                           && entry_q[e].qs2 == TAG_W'(TAG_NONE);
        for (genvar c = 0; c < CDB_N; c++) begin : g_ch
            for (genvar k = 0; k < 2; k++) begin : g_op
                assign m[e][k][c] = entry_q[e].busy && cv[c]
                                    && ctag[c] == ((k == 1) ? entry_q[e].qs2 : entry_q[e].qs1);
            end
        end
    end

    rs_prio_enc #(.N(DEPTH)) u_free (.req(free_v), .hit(free_hit), .idx(free_idx));
    rs_prio_enc #(.N(DEPTH)) u_rdy  (.req(rdy_v),  .hit(rdy_hit),  .idx(rdy_idx));

    assign in_ready  = en && count_q < CW'(DEPTH);
    assign out_valid = en && rdy_hit;
    assign alloc     = in_valid && in_ready;
    assign issue     = out_valid && out_ready;
    assign count     = count_q;
    assign out_op    = entry_q[rdy_idx].op;
    assign out_pc    = entry_q[rdy_idx].pc;
    assign out_imm   = entry_q[rdy_idx].imm;
    assign out_vs1   = entry_q[rdy_idx].vs1;
    assign out_vs2   = entry_q[rdy_idx].vs2;
    assign out_qd    = entry_q[rdy_idx].qd;

    always_comb begin
        entry_d = entry_q;
        nv = '{busy: 1'b1, op: in_op, pc: in_pc, imm: in_imm, qs1: in_qs1, qs2: in_qs2,
               vs1: in_vs1, vs2: in_vs2, qd: in_qd};
        // Descending loops so the lowest matching channel is the last writer.
        for (int c = CDB_N - 1; c >= 0; c--) begin
            if (b1[c]) begin nv.qs1 = '0; nv.vs1 = cdat[c]; end
            if (b2[c]) begin nv.qs2 = '0; nv.vs2 = cdat[c]; end
        end
        for (int e = 0; e < DEPTH; e++)
            for (int c = CDB_N - 1; c >= 0; c--) begin
                if (m[e][0][c]) begin entry_d[e].qs1 = '0; entry_d[e].vs1 = cdat[c]; end
                if (m[e][1][c]) begin entry_d[e].qs2 = '0; entry_d[e].vs2 = cdat[c]; end
            end
        if (issue) entry_d[rdy_idx].busy = 1'b0;
        if (alloc) entry_d[free_idx] = nv;
        count_d = count_q + CW'(alloc) - CW'(issue);
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            for (int e = 0; e < DEPTH; e++) entry_q[e] <= '0;
            count_q <= '0;
        end else if (en) begin
            entry_q <= entry_d;
            count_q <= count_d;
        end
    end

    logic unused_ok;
    assign unused_ok = free_hit;
endmodule

// File: tb/tb_rs_multi_cdb.sv
// tb_rs_multi_cdb: directed vectors with hand-computed expectations for rs_multi_cdb.
module tb_rs_multi_cdb;
    logic        clk = 0, rst = 1, en = 1, flush = 0;
    logic        in_valid = 0, in_ready, out_valid, out_ready = 0;
    logic [5:0]  in_op = 0, out_op;
    logic [31:0] in_pc = 0, in_imm = 0, in_vs1 = 0, in_vs2 = 0;
    logic [31:0] out_pc, out_imm, out_vs1, out_vs2;
    logic [4:0]  in_qs1 = 0, in_qs2 = 0, in_qd = 0, out_qd;
    logic [1:0]  cdb_valid = 0;
    logic [9:0]  cdb_tag = 0;
    logic [63:0] cdb_data = 0;
    logic [4:0]  count;
    int n_chk = 0, n_pass = 0;

    rs_multi_cdb dut (
        .clk(clk), .rst(rst), .en(en), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_pc(in_pc), .in_imm(in_imm),
        .in_qs1(in_qs1), .in_qs2(in_qs2), .in_vs1(in_vs1), .in_vs2(in_vs2), .in_qd(in_qd),
        .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op), .out_pc(out_pc),
        .out_imm(out_imm), .out_vs1(out_vs1), .out_vs2(out_vs2), .out_qd(out_qd),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data), .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic disp(input logic [5:0] op, input logic [4:0] q1, input logic [4:0] q2,
                        input logic [31:0] v1, input logic [31:0] v2, input logic [4:0] qd);
        in_valid = 1; in_op = op; in_qs1 = q1; in_qs2 = q2; in_vs1 = v1; in_vs2 = v2; in_qd = qd;
        step();
        in_valid = 0;
    endtask

    initial begin
        step();
        rst = 0;
        chk("rst_count", count, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);

        disp(3, 0, 0, 5, 7, 4);
        chk("t1_valid", out_valid, 1);
        chk("t1_op", out_op, 3);
        chk("t1_vs1", out_vs1, 5);
        chk("t1_vs2", out_vs2, 7);
        chk("t1_qd", out_qd, 4);
        chk("t1_count", count, 1);
        out_ready = 1; step(); out_ready = 0;
        chk("t1_count_after", count, 0);
        chk("t1_valid_after", out_valid, 0);

        disp(1, 9, 0, 0, 2, 7);
        chk("t2_wait", out_valid, 0);
        cdb_valid = 2'b10; cdb_tag = {5'd9, 5'd0}; cdb_data = {32'hABCD, 32'h0};
        #1 chk("t2_no_same_cycle", out_valid, 0);
        step(); cdb_valid = 0;
        chk("t2_wake", out_valid, 1);
        chk("t2_vs1", out_vs1, 32'hABCD);
        chk("t2_vs2", out_vs2, 2);
        out_ready = 1; step(); out_ready = 0;
        chk("t2_count", count, 0);

        cdb_valid = 2'b01; cdb_tag = {5'd0, 5'd6}; cdb_data = {32'h0, 32'h55};
        disp(2, 0, 6, 1, 0, 8);
        cdb_valid = 0;
        chk("t3_valid", out_valid, 1);
        chk("t3_vs2", out_vs2, 32'h55);
        out_ready = 1; step(); out_ready = 0;

        en = 0; in_valid = 1; #1;
        chk("en_in_ready", in_ready, 0);
        step(); in_valid = 0; en = 1;
        chk("en_hold_count", count, 0);

        for (int i = 0; i < 16; i++) disp(0, 0, 0, i, i, 5'(i + 1));
        chk("t4_full_count", count, 16);
        chk("t4_full_ready", in_ready, 0);
        chk("t4_head_qd", out_qd, 1);
        in_valid = 1; out_ready = 1; step(); in_valid = 0; out_ready = 0;
        chk("t4_count", count, 15);
        chk("t4_in_ready", in_ready, 1);
        chk("t4_next_qd", out_qd, 2);
        flush = 1; step(); flush = 0;
        chk("t4_flush_count", count, 0);

        disp(0, 3, 0, 0, 1, 10);
        disp(0, 8, 0, 0, 1, 11);
        disp(0, 0, 0, 1, 1, 12);
        disp(0, 0, 8, 1, 0, 13);
        disp(0, 8, 0, 0, 1, 14);
        disp(0, 0, 0, 1, 1, 15);
        chk("t5_count", count, 6);
        chk("t5_first_qd", out_qd, 12);
        out_ready = 1; step();
        chk("t5_second_qd", out_qd, 15);
        step(); out_ready = 0;
        chk("t5_none_ready", out_valid, 0);
        cdb_valid = 2'b11; cdb_tag = {5'd3, 5'd3}; cdb_data = {32'h22, 32'h11};
        step(); cdb_valid = 0;
        chk("t5_wake_qd", out_qd, 10);
        chk("t5_low_ch_wins", out_vs1, 32'h11);
        out_ready = 1; step(); out_ready = 0;
        chk("t5_count_end", count, 3);

        disp(0, 8, 0, 0, 0, 16);
        chk("t6_hold4", count, 4);
        flush = 1; in_valid = 1; in_qs1 = 0;
        cdb_valid = 2'b01; cdb_tag = {5'd0, 5'd8}; cdb_data = 64'h99;
        step(); flush = 0; in_valid = 0; cdb_valid = 0;
        chk("t6_flush_count", count, 0);
        chk("t6_flush_valid", out_valid, 0);
        chk("t6_flush_ready", in_ready, 1);
        disp(0, 0, 0, 1, 1, 17);
        chk("t6_refill", out_valid, 1);
        out_ready = 1; rst = 1; step(); rst = 0; out_ready = 0;
        chk("t6_rst_count", count, 0);
        chk("t6_rst_valid", out_valid, 0);
        chk("t6_rst_ready", in_ready, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
